// File: rtl/gng_mc_if.sv
// gng_mc_if: control/data bundle for the multi-channel Gaussian noise generator.
//   master: drives ce, mode (and seed_* when GNG_MC_SEED_PORT_EN is defined),
//           receives valid_out, data_out.
//   slave : the generator side (gng_mc).
// Optional feature macro: GNG_MC_SEED_PORT_EN (adds the runtime seed write port).
interface gng_mc_if #(
    parameter int unsigned CHANNELS = 4
);
    localparam int unsigned CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic                    ce;
    logic                    mode;
`ifdef GNG_MC_SEED_PORT_EN
    logic                    seed_we;
    logic [CH_W-1:0]         seed_ch;
    logic [1:0]              seed_sel;
    logic [63:0]             seed_data;
`endif
    logic                    valid_out;
    logic [16*CHANNELS-1:0]  data_out;

`ifdef GNG_MC_SEED_PORT_EN
    modport master (output ce, mode, seed_we, seed_ch, seed_sel, seed_data,
                    input  valid_out, data_out);
    modport slave  (input  ce, mode, seed_we, seed_ch, seed_sel, seed_data,
                    output valid_out, data_out);
`else
    modport master (output ce, mode, input  valid_out, data_out);
    modport slave  (input  ce, mode, output valid_out, data_out);
`endif
endinterface

// File: rtl/gng_mc.sv
// gng_mc: CHANNELS independent 64-bit combined Tausworthe URNGs, each followed by
// a 3-stage post-processing pipeline producing s<16,11> Gaussian (Irwin-Hall n=4)
// or raw uniform samples, selectable per sample by mode.
// Ports:
//   clk  - system clock
//   rst  - asynchronous active-high reset
//   bus  - gng_mc_if.slave: ce, mode, [seed_we, seed_ch, seed_sel, seed_data],
//          valid_out, data_out (channel c at [16c+15:16c])
// Optional feature macro: GNG_MC_SEED_PORT_EN (runtime per-channel seed reload).

// One channel: URNG state plus its sample pipeline.
module gng_mc_lane #(
    parameter logic [63:0] SEED1 = 64'h8000_0000_0000_0000,
    parameter logic [63:0] SEED2 = 64'h8000_0000_0000_0000,
    parameter logic [63:0] SEED3 = 64'h8000_0000_0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce_i,
    input  logic        ld_i,     // output register load (valid sample this edge)
    input  logic        mode_i,
    input  logic [2:0]  wr_i,     // seed write strobes for z3,z2,z1
    input  logic [63:0] wdata_i,
    output logic [15:0] data_o
);
    localparam logic [63:0] TOP = 64'h8000_0000_0000_0000;

    logic [63:0]        z1_q, z2_q, z3_q, z1_d, z2_d, z3_d;
    logic [63:0]        u_q;
    logic               m2_q, m3_q;
    logic [17:0]        s_q;
    logic [15:0]        raw_q, out_q, out_d;
    logic signed [18:0] x;
    logic signed [31:0] prod;
    logic               lane_unused;

    // URNG step; a seed write overrides the step for that register only.
    always_comb begin
        z1_d = z1_q;
        z2_d = z2_q;
        z3_d = z3_q;
        if (ce_i) begin
            z1_d = ((z1_q & ~64'h1)   << 10) ^ (((z1_q << 1)  ^ z1_q) >> 53);
            z2_d = ((z2_q & ~64'h1FF) << 5)  ^ (((z2_q << 24) ^ z2_q) >> 50);
            z3_d = ((z3_q & ~64'hFFF) << 29) ^ (((z3_q << 3)  ^ z3_q) >> 23);
        end
        // Bit 63 forced so the per-component minimum-value constraints always hold.
        if (wr_i[0]) z1_d = wdata_i | TOP;
        if (wr_i[1]) z2_d = wdata_i | TOP;
        if (wr_i[2]) z3_d = wdata_i | TOP;
    end

    // Centre the Irwin-Hall sum and scale; taking the top half of the product is
    // an arithmetic shift by 16, i.e. floor rounding.
    always_comb begin
        x     = $signed({1'b0, s_q}) - 19'sd131072;
        prod  = 32'(x) * 32'sd3547;
        out_d = m3_q ? raw_q : prod[31:16];
    end
    assign lane_unused = ^prod[15:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            z1_q  <= SEED1;
            z2_q  <= SEED2;
            z3_q  <= SEED3;
            u_q   <= '0;
            m2_q  <= 1'b0;
            s_q   <= '0;
            raw_q <= '0;
            m3_q  <= 1'b0;
            out_q <= '0;
        end else begin
            z1_q <= z1_d;
            z2_q <= z2_d;
            z3_q <= z3_d;
            if (ce_i) begin
                u_q   <= z1_q ^ z2_q ^ z3_q;
                m2_q  <= mode_i;
                s_q   <= {2'b0, u_q[15:0]}  + {2'b0, u_q[31:16]} +
                         {2'b0, u_q[47:32]} + {2'b0, u_q[63:48]};
                raw_q <= u_q[15:0];
                m3_q  <= m2_q;
            end
            // Only valid samples reach the output, so fill garbage never shows.
            if (ld_i) out_q <= out_d;
        end
    end

    assign data_o = out_q;
endmodule

module gng_mc #(
    parameter int unsigned CHANNELS = 4,
    parameter logic [63:0] INIT_Z1  = 64'd5030521853213464767,
    parameter logic [63:0] INIT_Z2  = 64'd18445829279764255008,
    parameter logic [63:0] INIT_Z3  = 64'd18436106598722573559
) (
    input  logic     clk,
    input  logic     rst,
    gng_mc_if.slave  bus
);
    localparam int unsigned CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [63:0] GOLD = 64'h9E3779B97F4A7C15;
    localparam logic [63:0] TOP  = 64'h8000_0000_0000_0000;

    logic [2:0]                  cnt_q;
    logic                        valid_q, ld;
    logic [CHANNELS-1:0][15:0]   dat;

    // Output loads on the same edges that raise valid_out.
    assign ld = bus.ce && (cnt_q >= 3'd3);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= ld;
            if (bus.ce && cnt_q != 3'd4) cnt_q <= cnt_q + 3'd1;
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
        localparam logic [63:0] MIX = 64'(c) * GOLD;
        logic [2:0]  wr;
        logic [63:0] wd;
`ifdef GNG_MC_SEED_PORT_EN
        logic hit;
        // Out-of-range seed_ch values match no lane and are dropped.
        assign hit = bus.seed_we && (bus.seed_ch == CH_W'(c));
        assign wr  = {3{hit}} & {bus.seed_sel == 2'd3, bus.seed_sel == 2'd2,
                                 bus.seed_sel == 2'd1};
        assign wd  = bus.seed_data;
`else
        assign wr  = 3'b000;
        assign wd  = '0;
`endif
        gng_mc_lane #(
            .SEED1((INIT_Z1 ^ MIX) | TOP),
            .SEED2((INIT_Z2 ^ MIX) | TOP),
            .SEED3((INIT_Z3 ^ MIX) | TOP)
        ) u_lane (
            .clk    (clk),
            .rst    (rst),
            .ce_i   (bus.ce),
            .ld_i   (ld),
            .mode_i (bus.mode),
            .wr_i   (wr),
            .wdata_i(wd),
            .data_o (dat[c])
        );
    end

    assign bus.valid_out = valid_q;
    assign bus.data_out  = dat;
endmodule

// File: tb/tb_gng_mc.sv
// tb_gng_mc: randomized bench for gng_mc against a transaction-level model
// (sample queue + integer Gaussian math). Seed-port tests run when
// GNG_MC_SEED_PORT_EN is defined.
module tb_gng_mc;
    localparam int CH = 4;
    localparam logic [63:0] Z1   = 64'd5030521853213464767;
    localparam logic [63:0] Z2   = 64'd18445829279764255008;
    localparam logic [63:0] Z3   = 64'd18436106598722573559;
    localparam logic [63:0] GOLD = 64'h9E3779B97F4A7C15;
    localparam logic [63:0] TOP  = 64'h8000_0000_0000_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;

    gng_mc_if #(.CHANNELS(CH)) bus ();

    gng_mc #(.CHANNELS(CH), .INIT_Z1(Z1), .INIT_Z2(Z2), .INIT_Z3(Z3)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int same_cnt = 0;

    logic [63:0]         zm [CH][3];
    logic [16*CH-1:0]    q [$];
    logic [16*CH-1:0]    exp_d;
    logic                exp_v;
    int                  fill;
    logic                run1_mode [30];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] stp(input int k, input logic [63:0] z);
        case (k)
            0:       return ((z & ~64'h1)   << 10) ^ (((z << 1)  ^ z) >> 53);
            1:       return ((z & ~64'h1FF) << 5)  ^ (((z << 24) ^ z) >> 50);
            default: return ((z & ~64'hFFF) << 29) ^ (((z << 3)  ^ z) >> 23);
        endcase
    endfunction

    function automatic logic [15:0] gen(input logic [63:0] u, input logic m);
        longint s, p, qv;
        if (m) return u[15:0];
        s  = longint'(u[15:0]) + longint'(u[31:16]) + longint'(u[47:32]) + longint'(u[63:48]);
        p  = (s - 131072) * 3547;
        qv = p / 65536;
        if (p < 0 && (p % 65536) != 0) qv = qv - 1;
        return 16'(qv);
    endfunction

    task automatic model_reset();
        logic [63:0] init [3];
        init[0] = Z1; init[1] = Z2; init[2] = Z3;
        for (int c = 0; c < CH; c++)
            for (int k = 0; k < 3; k++)
                zm[c][k] = (init[k] ^ (64'(c) * GOLD)) | TOP;
        q.delete();
        fill  = 0;
        exp_d = '0;
        exp_v = 1'b0;
    endtask

    // One clock: drive inputs, advance the model by the edge, compare.
    task automatic tick(input logic ce, input logic m, input logic we, input int ch,
                        input logic [1:0] sel, input logic [63:0] wd);
        logic [16*CH-1:0] smp;
        logic             alleq;
        @(negedge clk);
        bus.ce   = ce;
        bus.mode = m;
`ifdef GNG_MC_SEED_PORT_EN
        bus.seed_we   = we;
        bus.seed_ch   = ch[1:0];
        bus.seed_sel  = sel;
        bus.seed_data = wd;
`endif
        @(posedge clk);
        exp_v = ce && (fill >= 3);
        if (ce) begin
            // A sample is captured on every enabled edge after the first.
            if (fill >= 1) begin
                for (int c = 0; c < CH; c++)
                    smp[16*c +: 16] = gen(zm[c][0] ^ zm[c][1] ^ zm[c][2], m);
                q.push_back(smp);
            end
            for (int c = 0; c < CH; c++)
                for (int k = 0; k < 3; k++)
                    zm[c][k] = stp(k, zm[c][k]);
            if (fill < 4) fill++;
        end
        if (we && sel != 2'd0 && ch < CH) zm[ch][int'(sel) - 1] = wd | TOP;
        if (exp_v && q.size() > 0) exp_d = q.pop_front();
        #1;
        chk("valid", {63'd0, bus.valid_out}, {63'd0, exp_v});
        for (int c = 0; c < CH; c++)
            chk($sformatf("data_ch%0d", c), {48'd0, bus.data_out[16*c +: 16]}, {48'd0, exp_d[16*c +: 16]});
        if (exp_v) begin
            alleq = 1'b1;
            for (int c = 1; c < CH; c++)
                if (bus.data_out[16*c +: 16] != bus.data_out[15:0]) alleq = 1'b0;
            if (alleq) same_cnt++;
        end
    endtask

    task automatic reset_mid();
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_valid", {63'd0, bus.valid_out}, 64'd0);
        chk("rst_mid_data", 64'(bus.data_out), 64'd0);
        @(negedge clk);
        bus.ce = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        bus.ce   = 1'b0;
        bus.mode = 1'b0;
`ifdef GNG_MC_SEED_PORT_EN
        bus.seed_we   = 1'b0;
        bus.seed_ch   = '0;
        bus.seed_sel  = 2'd0;
        bus.seed_data = '0;
`endif
        model_reset();
        repeat (3) begin
            @(negedge clk);
            chk("rst_valid", {63'd0, bus.valid_out}, 64'd0);
            chk("rst_data", 64'(bus.data_out), 64'd0);
        end
        rst = 1'b0;

        // First run: continuous enable, random mode per sample.
        for (int i = 0; i < 30; i++) begin
            run1_mode[i] = 1'($urandom_range(0, 1));
            tick(1'b1, run1_mode[i], 1'b0, 0, 2'd0, 64'd0);
        end

        // ce toggling every cycle, occasional mode flips.
        for (int i = 0; i < 1000; i++)
            tick((i % 2) == 0, 1'($urandom_range(0, 1)), 1'b0, 0, 2'd0, 64'd0);

        // Random enable pattern.
        for (int i = 0; i < 300; i++)
            tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 0, 2'd0, 64'd0);

`ifdef GNG_MC_SEED_PORT_EN
        // Zero seeds on ch0, Gaussian then uniform.
        for (int pass = 0; pass < 2; pass++) begin
            for (int k = 1; k <= 3; k++) tick(1'b0, 1'b0, 1'b1, 0, 2'(k), 64'd0);
            for (int e = 0; e < 4; e++) tick(1'b1, 1'(pass), 1'b0, 0, 2'd0, 64'd0);
            chk(pass == 0 ? "seed_gauss" : "seed_unif", {48'd0, bus.data_out[15:0]},
                pass == 0 ? 64'hE64A : 64'h2400);
        end
        // Random writes while running.
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 7) == 0)
                tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1,
                     int'($urandom_range(0, CH - 1)), 2'($urandom_range(0, 3)),
                     {$urandom, $urandom});
            else
                tick(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 1'b0, 0, 2'd0, 64'd0);
        end
`endif

        // Mid-stream reset, then replay the first run.
        reset_mid();
        for (int i = 0; i < 30; i++)
            tick(1'b1, run1_mode[i], 1'b0, 0, 2'd0, 64'd0);

        chk("distinct", 64'(same_cnt), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/gng_mc.md
# gng_mc

Multi-channel Gaussian noise generator: parametrised successor to the single-channel `gng`, intended for the same test and verification flow. Each of `CHANNELS` lanes runs an independent 64-bit combined Tausworthe URNG. A per-sample mode selects either a central-limit (Irwin-Hall, n=4) Gaussian approximation or raw uniform output. Runtime seed reload lets benches and system software re-seed individual channels without reset. Output is s<16,11> per channel on a flat bus, with a shared `valid_out`.

## Interface
- `CHANNELS`, 4: number of independent channels; range 1..16.
- `INIT_Z1`, 64'd5030521853213464767: base seed, URNG component 1.
- `INIT_Z2`, 64'd18445829279764255008: base seed, component 2.
- `INIT_Z3`, 64'd18436106598722573559: base seed, component 3.

Ports:
- `clk`  in  1  system clock. One clock; reset is asynchronous and active-high.
- `rst`  in  1  asynchronous reset, active-high.
- `ce`  in  1  clock enable; the pipeline advances only on edges where `ce`=1.
- `mode`  in  1  0 = Gaussian, 1 = raw uniform; sampled per sample at stage 2.
- `seed_we`  in  1  seed write strobe (only with `GNG_MC_SEED_PORT_EN`).
- `seed_ch`  in  max(1,clog2(CHANNELS))  target channel (only with the macro).
- `seed_sel`  in  2  1=z1, 2=z2, 3=z3; 0 = no-op (only with the macro).
- `seed_data`  in  64  seed value (only with the macro).
- `valid_out`  out  1  `data_out` holds a new sample this cycle.
- `data_out`  out  16*CHANNELS  channel c at [16c+15:16c], s<16,11>.

## Operation
- Reset seeds: channel c, component k: `INIT_Zk ^ (c * 64'h9E3779B97F4A7C15)`, bit 63 forced to 1. Forcing bit 63 guarantees the z1>1, z2>511 and z3>4095 constraints.
- URNG step on each enabled edge (64-bit, truncating shifts):
  - z1 = ((z1 & ~64'h1) << 10) ^ (((z1<<1)^z1) >> 53)
  - z2 = ((z2 & ~64'h1FF) << 5) ^ (((z2<<24)^z2) >> 50)
  - z3 = ((z3 & ~64'hFFF) << 29) ^ (((z3<<3)^z3) >> 23)
- Stage 1: z update.
- Stage 2: u = z1^z2^z3 (post-update values); `mode` captured alongside u.
- Stage 3: s = sum of the four 16-bit unsigned lanes of u (18 bit); raw = u[15:0]; mode travels with the sample.
- Stage 4 (`data_out`):
  - Gaussian: x = s − 131072 (signed 19 bit); out = (x*3547) >>> 16, floor rounding, range [−7094, 7093].
  - Uniform: out = raw.
- A `mode` change affects only samples whose u is captured after the change; no in-flight sample mixes modes.
- Seed write: when `seed_we`=1 and `seed_sel`≠0, the selected z register gets `seed_data | (1<<63)` on the next edge, regardless of `ce`.
  - If `ce`=1 on the same edge, the write wins for that register. The channel's other z registers step normally.
  - Samples in flight are not flushed.
  - `seed_ch` ≥ CHANNELS is ignored.

## Timing
- Reset values: `data_out`=0, `valid_out`=0, fill counter=0, all pipeline registers 0, z = reset seeds. Reset is asynchronous and takes effect mid-stream with no partial output.
- Fill counter: saturates at 4 and increments on enabled edges.
- `valid_out` is registered: on each edge, `valid_out` ← `ce` && (counter ≥ 3 before the edge).
  - The first valid sample appears on the 4th enabled edge after reset.
  - Thereafter there is 1 sample per channel per enabled edge.
- `ce`=0: all state holds; `valid_out` drops to 0 on that edge. The counter is not cleared, so `valid_out` returns to 1 on the next enabled edge.
- Latency from seed write to first output using the new seed: 4 enabled edges.

## Configuration
- `GNG_MC_SEED_PORT_EN`
  - Defined: the `seed_*` ports and write logic exist.
  - Undefined: the ports are absent, seeds come only from parameters, and the behaviour is otherwise identical.

## Test plan
- Reset with `ce`=0 for 3 cycles -> `valid_out`=0 and `data_out`=0 throughout.
- Deassert `rst`, hold `ce`=1 -> `valid_out` first 1 on the 4th edge, then continuously 1.
- With `ce`=0, write 64'd0 to ch0 z1, z2, z3, then `ce`=1, `mode`=0 -> on the 4th edge, `data_out[15:0]`=16'hE64A (u=64'h0000010000002400, s=9472, out=−6582).
- Same as above with `mode`=1 -> `data_out[15:0]`=16'h2400. Toggling `mode` mid-stream changes the output exactly 3 enabled edges later.
- `ce` toggled 1/0 every cycle over 1000 cycles -> `valid_out` matches `ce` delayed one cycle. The sample sequence is bit-exact against a C model, and channels are mutually distinct.
- Assert `rst` mid-stream -> outputs are 0 immediately. After release, the sequence restarts identical to the first run.
